// File: rtl/uprog_store_loader_pkg.sv
// Shared types and defaults for the control-store loader.
// State encoding is fixed so the FSM and its debug views agree.
package uprog_pkg;

    localparam int D_W_DEF = 4;
    localparam int A_W_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_VERIFY = 3'd2,
        S_RUN    = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/uprog_store_loader_if.sv
// Word-stream handshake plus control-store bus of the loader.
// master = loader side, slave = source / memory side.
interface uprog_store_loader_if #(
    parameter int D_W = 4,
    parameter int A_W = 4
);
    logic           in_valid;
    logic [D_W-1:0] in_data;
    logic           in_ready;
    logic           mem_we;
    logic [A_W-1:0] mem_addr;
    logic [D_W-1:0] mem_wdata;
    logic [D_W-1:0] mem_rdata;

    modport master (
        input  in_valid, in_data, mem_rdata,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output in_valid, in_data, mem_rdata,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/uprog_store_loader_csum.sv
// Modulo-2**W running sum with async clear and a synchronous restart.
module uprog_csum #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         clr_sync,
    input  logic         add_en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sum
);
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            sum <= '0;
        end else if (clr_sync) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + din;
        end
    end
endmodule

// File: rtl/uprog_store_loader.sv
// Streams a microprogram into the control store, reads it back against
// a checksum, and only then hands the store to the FSM via run_en.
module uprog_store_loader
    import uprog_pkg::*;
#(
    parameter int D_W = D_W_DEF,
    parameter int A_W = A_W_DEF
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                load_start,
    uprog_store_loader_if.master bus,
    output logic                run_en,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam logic [A_W-1:0] LAST = '1;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [A_W-1:0] r_addr;
    logic [A_W-1:0] w_addr_nxt;
    logic           w_clr;
    logic           w_wadd;
    logic           w_vadd;
    logic [D_W-1:0] w_wsum;
    logic [D_W-1:0] w_vsum;
    logic [D_W-1:0] w_vnext;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // Readback sum including the word on the bus this cycle.
    assign w_vnext = w_vsum + bus.mem_rdata;

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_clr         = 1'b0;
        w_wadd        = 1'b0;
        w_vadd        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        unique case (r_state)
            S_IDLE, S_RUN, S_ERROR: begin
                if (load_start) begin
                    w_state_nxt = S_WRITE;
                    w_addr_nxt  = '0;
                    w_clr       = 1'b1;
                end
            end
            S_WRITE: begin
                bus.in_ready  = 1'b1;
                bus.mem_addr  = r_addr;
                bus.mem_wdata = bus.in_data;
                bus.mem_we    = bus.in_valid;
                if (bus.in_valid) begin
                    w_wadd     = 1'b1;
                    w_addr_nxt = r_addr + 1'b1;
                    if (r_addr == LAST) begin
                        w_state_nxt = S_VERIFY;
                    end
                end
            end
            S_VERIFY: begin
                bus.mem_addr = r_addr;
                w_vadd       = 1'b1;
                w_addr_nxt   = r_addr + 1'b1;
                if (r_addr == LAST) begin
                    w_state_nxt = (w_vnext == w_wsum) ? S_RUN : S_ERROR;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_addr_nxt  = '0;
            end
        endcase
    end

    uprog_csum #(.W(D_W)) u_wsum (
        .CLK      (CLK),
        .CLR      (CLR),
        .clr_sync (w_clr),
        .add_en   (w_wadd),
        .din      (bus.in_data),
        .sum      (w_wsum)
    );

    uprog_csum #(.W(D_W)) u_vsum (
        .CLK      (CLK),
        .CLR      (CLR),
        .clr_sync (w_clr),
        .add_en   (w_vadd),
        .din      (bus.mem_rdata),
        .sum      (w_vsum)
    );

    assign run_en = (r_state == S_RUN);
    assign done   = (r_state == S_RUN);
    assign err    = (r_state == S_ERROR);
    assign busy   = (r_state == S_WRITE) || (r_state == S_VERIFY);
endmodule

// File: tb/tb_uprog_store_loader.sv
// Scoreboarded bench for the control-store loader.
module tb_uprog_store_loader;
    logic CLK;
    logic CLR;
    logic load_start;
    logic run_en, busy, done, err;
    logic corrupt;
    logic [3:0] mem [16];
    logic [7:0] q [$];
    logic [3:0] exp_addr;
    int n_chk, n_fail, n_wr, n_busy;

    uprog_store_loader_if #(.D_W(4), .A_W(4)) ifc ();

    uprog_store_loader #(.D_W(4), .A_W(4)) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .load_start (load_start),
        .bus        (ifc),
        .run_en     (run_en),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: write on the edge, combinational read, optional bit flip.
    always @(posedge CLK) begin
        if (ifc.mem_we) mem[ifc.mem_addr] <= ifc.mem_wdata;
    end
    assign ifc.mem_rdata = mem[ifc.mem_addr] ^
        ((corrupt && ifc.mem_addr == 4'd5) ? 4'd1 : 4'd0);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        logic [7:0] e;
        if (busy) n_busy++;
        if (ifc.mem_we) begin
            n_wr++;
            if (q.size() == 0) begin
                chk("sb_extra_write", 1, 0);
            end else begin
                e = q.pop_front();
                chk("wr_addr", ifc.mem_addr, e[7:4]);
                chk("wr_data", ifc.mem_wdata, e[3:0]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick(1);
        load_start = 1'b0;
        exp_addr = '0;
        n_wr = 0;
        n_busy = 0;
    endtask

    task automatic send_word(input logic [3:0] d);
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        q.push_back({exp_addr, d});
        tick(1);
        ifc.in_valid = 1'b0;
        exp_addr = exp_addr + 1'b1;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_in_ready"}, ifc.in_ready, 0);
        chk({tag, "_mem_we"}, ifc.mem_we, 0);
        chk({tag, "_mem_addr"}, ifc.mem_addr, 0);
        chk({tag, "_mem_wdata"}, ifc.mem_wdata, 0);
        chk({tag, "_run_en"}, run_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; n_wr = 0; n_busy = 0;
        corrupt = 1'b0;
        exp_addr = '0;
        for (int i = 0; i < 16; i++) mem[i] = 4'd0;
        CLR = 1'b1;
        load_start = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data = '0;
        tick(2);
        chk_idle_outs("reset");
        CLR = 1'b0;
        tick(1);

        // Nominal load: words 0..15, continuous.
        start_load();
        chk("t1_busy_after_start", busy, 1);
        for (int i = 0; i < 16; i++) send_word(4'(i));
        chk("t1_wsum", dut.w_wsum, 8);
        tick(15);
        chk("t1_run_en_edge32", run_en, 0);
        chk("t1_busy_edge32", busy, 1);
        tick(1);
        chk("t1_run_en_edge33", run_en, 1);
        chk("t1_done", done, 1);
        chk("t1_err", err, 0);
        chk("t1_busy_off", busy, 0);
        chk("t1_n_busy", n_busy, 32);
        chk("t1_n_wr", n_wr, 16);
        chk("t1_q_empty", q.size(), 0);

        // Backpressure: valid alternates 1/0.
        start_load();
        chk("t2_run_drop", run_en, 0);
        for (int i = 0; i < 16; i++) begin
            send_word(4'((i * 7 + 3) & 15));
            if (i < 15) begin
                tick(1);
                chk("t2_hold_addr", ifc.mem_addr, exp_addr);
            end
        end
        tick(15);
        chk("t2_run_en_early", run_en, 0);
        tick(1);
        chk("t2_run_en", run_en, 1);
        chk("t2_n_wr", n_wr, 16);
        chk("t2_q_empty", q.size(), 0);

        // Corrupt readback of word 5, then clean retry.
        corrupt = 1'b1;
        start_load();
        for (int i = 0; i < 16; i++) send_word(4'(15 - i));
        tick(16);
        chk("t3_err", err, 1);
        chk("t3_run_en", run_en, 0);
        chk("t3_done", done, 0);
        corrupt = 1'b0;
        start_load();
        for (int i = 0; i < 16; i++) send_word(4'(i ^ 5));
        tick(16);
        chk("t3_retry_run", run_en, 1);
        chk("t3_retry_err", err, 0);
        chk("t3_q_empty", q.size(), 0);

        // Reload with all-F words, with ignored starts in WRITE and VERIFY.
        start_load();
        chk("t5_run_drop", run_en, 0);
        for (int i = 0; i < 8; i++) send_word(4'hF);
        load_start = 1'b1;
        tick(1);
        load_start = 1'b0;
        chk("t5_wr_ign_busy", busy, 1);
        chk("t5_wr_ign_ready", ifc.in_ready, 1);
        chk("t5_wr_ign_addr", ifc.mem_addr, 8);
        for (int i = 8; i < 16; i++) send_word(4'hF);
        chk("t5_wsum", dut.w_wsum, 0);
        tick(5);
        load_start = 1'b1;
        tick(1);
        load_start = 1'b0;
        chk("t5_vf_ign_ready", ifc.in_ready, 0);
        chk("t5_vf_ign_busy", busy, 1);
        chk("t5_vf_ign_addr", ifc.mem_addr, 6);
        tick(10);
        chk("t5_run_en", run_en, 1);
        chk("t5_n_wr", n_wr, 16);

        // Async reset mid-WRITE at addr 7.
        start_load();
        for (int i = 0; i < 7; i++) send_word(4'(i + 2));
        chk("t4_addr7", ifc.mem_addr, 7);
        #3;
        CLR = 1'b1;
        #1;
        chk_idle_outs("t4_clr");
        for (int i = 0; i < 4; i++) begin
            ifc.in_valid = 1'b1;
            @(negedge CLK);
            chk("t4_no_we", ifc.mem_we, 0);
            ifc.in_valid = 1'b0;
            tick(1);
        end
        CLR = 1'b0;
        tick(3);
        chk_idle_outs("t4_idle");
        chk("t4_q_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uprog_store_loader.md
Name: uprog_store_loader

Overview:
Loader/controller for the writable control store of the micro-programmable FSM. After a start request it streams a full microprogram into the control memory through a valid/ready handshake. It then reads the whole memory back and checks it against a running checksum. Only after a passing check does it release the FSM, via run_en; while run_en is low, the memory bus belongs to this block and the FSM state register is held cleared.

Parameters:
D_W, 4, control-word width: next-state bits plus output bits
A_W, 4, control-store address width; depth is 2**A_W words

Ports:
CLK  input  1  clock; all state changes on the rising edge
CLR  input  1  asynchronous, active-high reset
load_start  input  1  request a (re)load; sampled on the rising edge
in_valid  input  1  in_data holds a control word
in_data  input  D_W  microprogram word for the current address
in_ready  output  1  loader accepts in_data this cycle
mem_we  output  1  control-store write enable; write occurs on the rising edge
mem_addr  output  A_W  control-store address while run_en=0
mem_wdata  output  D_W  control-store write data
mem_rdata  input  D_W  control-store read data; combinational read of mem_addr
run_en  output  1  1 = FSM owns the store and its state register runs
busy  output  1  state is WRITE or VERIFY
done  output  1  load verified (high throughout RUN)
err  output  1  verify mismatch (high throughout ERROR)

Behaviour:
- States: IDLE, WRITE, VERIFY, RUN, ERROR.
- Reset (CLR=1, asynchronous): state=IDLE, address counter=0, write sum=0, verify sum=0.
  - All outputs read 0 during reset: in_ready, mem_we, mem_addr, mem_wdata, run_en, busy, done, err.
  - Control-store contents are not touched.
- IDLE:
  - load_start=1 -> WRITE; clear address counter and both sums.
  - All other inputs are ignored.
- WRITE:
  - in_ready=1, mem_addr=addr, mem_wdata=in_data.
  - mem_we = in_valid & in_ready (combinational).
  - On an accept edge: addr+1; wsum = (wsum + in_data) mod 2**D_W.
  - in_valid=0 -> hold; nothing is written and nothing is consumed.
  - Accept at addr = 2**A_W-1 -> VERIFY with addr=0 (wrap-around).
  - load_start is ignored.
- VERIFY:
  - in_ready=0, mem_we=0, mem_addr=addr.
  - Each edge: vsum = vsum + mem_rdata (mod 2**D_W), then addr+1.
  - Takes exactly 2**A_W cycles.
  - On the last edge, compare (vsum + mem_rdata) with wsum: equal -> RUN, otherwise -> ERROR.
  - load_start is ignored.
- RUN:
  - run_en=1, done=1; mem_we=0, mem_addr=0, mem_wdata=0.
  - load_start=1 -> WRITE; run_en falls on that same edge and both sums clear.
- ERROR:
  - err=1, run_en=0.
  - load_start=1 -> WRITE (retry).
- Output timing: run_en, busy, done and err are registered-state decodes, so they are glitch-free.
- Latency with continuous in_valid and defaults: 1 edge (start) + 16 (write) + 16 (verify) = 33. run_en is high after the 33rd rising edge counted from the edge that samples load_start.
- CLR mid-operation: immediate return to reset values. A partially written store is left as-is, and run_en stays 0 until a full load passes.

Decomposition:
- Package uprog_pkg holds:
  - the state encoding (3-bit, IDLE=0 ... ERROR=4);
  - default D_W and A_W.
- One natural sub-module, uprog_csum:
  - parameter W; ports CLK, CLR, clr_sync, add_en, din, sum;
  - modulo-2**W accumulator, instantiated twice (wsum, vsum).
- State and address registers reuse the existing parameterised register with async CLR.

Test Plan:
1. Nominal load:
   - Stimulus: CLR pulse; load_start=1 for one cycle; stream words 0..15 continuously into a correct memory model.
   - Response: mem_we high for exactly 16 edges with addr i / data i; wsum=8; busy for 32 cycles; after edge 33, run_en=1, done=1, err=0.
2. Backpressure:
   - Stimulus: in_valid alternates 1/0 during WRITE.
   - Response: only accepted cycles advance the address; still exactly 16 writes with no duplicates; run_en rises 16 cycles after the last accept.
3. Corrupt readback:
   - Stimulus: the memory model flips bit 0 of word 5 on read.
   - Response: ERROR, err=1, run_en=0, done=0. A new load_start with a clean model then reaches RUN with err=0.
4. Async reset:
   - Stimulus: assert CLR between clock edges while addr=7 in WRITE.
   - Response: all outputs 0 immediately; while CLR stays high, in_valid pulses produce no mem_we; after release the block sits in IDLE.
5. Reload and ignored starts:
   - Stimulus: load_start during RUN, then a stream of 16 words 4'hF.
   - Response: run_en drops on that edge; wsum=0; block returns to RUN.
   - Stimulus: load_start pulses during WRITE and VERIFY.
   - Response: no state or address change.
